// File: rtl/uc_pkg.sv
// uc_pkg: opcode, FSM state and sizing constants shared by the uc_exec execute stage
package uc_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int MUL_STEPS_DEF = 8;
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR = 3;
  localparam int OP_XOR = 4;
  localparam int OP_NOTA = 5;
  localparam int OP_SHL = 6;
  localparam int OP_SHR = 7;
  localparam int OP_MUL = 8;
  localparam int OP_MOVB = 9;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EXEC = 2'd2, WRITE = 2'd3} state_t;
endpackage

// File: rtl/uc_mul8.sv
// uc_mul8: shift-add multiplier (clock, reset active-low, go loads a/b, done pulses in the last step with product valid)
module uc_mul8 #(
  parameter int W = 8,
  parameter int STEPS = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           go,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  logic [2*W-1:0] acc, mcand, sum;
  logic [W-1:0] mplier;
  logic [CW-1:0] cnt;
  logic run;
  assign sum = acc + (mplier[0] ? mcand : '0);
  assign done = run && cnt == LAST;
  assign product = sum;
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (go) begin
      acc <= '0;
      mcand <= {{W{1'b0}}, a};
      mplier <= b;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      acc <= sum;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      run <= !done;
    end
  end
endmodule

// File: rtl/uc_exec.sv
// uc_exec: 8-bit execute stage (start rise -> LOAD/EXEC/WRITE, result on tempRegA with one-cycle flagUC, flags carry/zero/error, busy, state)
module uc_exec import uc_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int MUL_STEPS = MUL_STEPS_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] regA,
  input  logic [WIDTH-1:0] regB,
  input  logic [WIDTH-1:0] opcode,
  output logic [WIDTH-1:0] tempRegA,
  output logic             flagUC,
  output logic             busy,
  output logic             carry,
  output logic             zero,
  output logic             error,
  output logic [1:0]       state
);
  state_t st, nx;
  logic start_d, rise, is_mul, mdone, cy, er;
  logic [WIDTH-1:0] opa, opb, op, res;
  logic [2*WIDTH-1:0] prod;
  assign rise = start && !start_d;
  assign is_mul = op == WIDTH'(OP_MUL);
  assign state = st;
  assign busy = st != IDLE;
  assign flagUC = st == WRITE;
  uc_mul8 #(.W(WIDTH), .STEPS(MUL_STEPS)) u_mul (
    .clock(clock),
    .reset(reset),
    .go(st == LOAD && opcode == WIDTH'(OP_MUL)),
    .a(regA),
    .b(regB),
    .done(mdone),
    .product(prod)
  );
  always_comb begin
    nx = st == IDLE ? (rise ? LOAD : IDLE) :
         st == LOAD ? EXEC :
         st == EXEC ? ((!is_mul || mdone) ? WRITE : EXEC) : IDLE;
  end
  always_comb begin
    res = opa;
    cy = 1'b0;
    er = 1'b0;
    case (op)
      WIDTH'(OP_ADD):  {cy, res} = {1'b0, opa} + {1'b0, opb};
      WIDTH'(OP_SUB):  {cy, res} = {1'b0, opa} - {1'b0, opb};
      WIDTH'(OP_AND):  res = opa & opb;
      WIDTH'(OP_OR):   res = opa | opb;
      WIDTH'(OP_XOR):  res = opa ^ opb;
      WIDTH'(OP_NOTA): res = ~opa;
      WIDTH'(OP_SHL):  {cy, res} = {opa, 1'b0};
      WIDTH'(OP_SHR):  {res, cy} = {1'b0, opa};
      WIDTH'(OP_MUL):  {cy, res} = {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]};
      WIDTH'(OP_MOVB): res = opb;
      default:         er = 1'b1;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) st <= IDLE;
    else st <= nx;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      start_d <= 1'b0;
      opa <= '0;
      opb <= '0;
      op <= '0;
      tempRegA <= '0;
      carry <= 1'b0;
      zero <= 1'b0;
      error <= 1'b0;
    end else begin
      start_d <= start;
      if (st == IDLE && rise) error <= 1'b0;
      if (st == LOAD) begin
        opa <= regA;
        opb <= regB;
        op <= opcode;
      end
      if (st == EXEC && nx == WRITE) begin
        tempRegA <= res;
        carry <= cy;
        zero <= res == '0;
        error <= er;
      end
    end
  end
endmodule

// File: tb/tb_uc_exec.sv
// tb_uc_exec: randomized scoreboard bench for uc_exec against an arithmetic reference model
module tb_uc_exec;
  logic clock = 0, reset = 0, start = 0;
  logic [7:0] regA = 0, regB = 0, opcode = 0;
  logic [7:0] tempRegA;
  logic flagUC, busy, carry, zero, error;
  logic [1:0] state;
  typedef struct { int r; int c; int z; int e; int k; int lat; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0;
  logic prev_flag = 0;
  uc_exec dut (
    .clock(clock), .reset(reset), .start(start), .regA(regA), .regB(regB), .opcode(opcode),
    .tempRegA(tempRegA), .flagUC(flagUC), .busy(busy), .carry(carry), .zero(zero),
    .error(error), .state(state)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask
  function automatic exp_t model(input int a, input int b, input int o);
    exp_t x;
    int r;
    x.c = 0;
    x.e = 0;
    case (o)
      0: begin r = a + b; x.c = int'(r > 255); end
      1: begin r = a - b; x.c = int'(a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = a * 2; x.c = int'(a >= 128); end
      7: begin r = a / 2; x.c = a % 2; end
      8: begin r = a * b; x.c = int'(r > 255); end
      9: r = b;
      default: begin r = a; x.e = 1; end
    endcase
    x.r = r & 255;
    x.z = int'(x.r == 0);
    x.lat = (o == 8) ? 9 : 2;
    return x;
  endfunction
  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask
  task automatic issue(input int a, input int b, input int o, input int hold);
    exp_t x;
    wait_idle();
    @(negedge clock);
    regA = 8'(a);
    regB = 8'(b);
    opcode = 8'(o);
    start = 1;
    x = model(a, b, o);
    x.k = cyc + 1;
    q.push_back(x);
    @(negedge clock);
    chk("busy_after_k", int'(busy), 1);
    chk("state_load", int'(state), 1);
    chk("error_cleared", int'(error), 0);
    @(negedge clock);
    regA = 8'($urandom);
    regB = 8'($urandom);
    opcode = 8'($urandom);
    repeat (hold - 2) @(negedge clock);
    start = 0;
  endtask
  always @(negedge clock) begin
    if (flagUC) begin
      if (q.size() == 0) chk("spurious_flagUC", 1, 0);
      else begin
        exp_t x;
        x = q.pop_front();
        chk("result", int'(tempRegA), x.r);
        chk("carry", int'(carry), x.c);
        chk("zero", int'(zero), x.z);
        chk("error", int'(error), x.e);
        chk("latency", cyc - x.k, x.lat);
      end
      if (prev_flag) chk("flag_width", 2, 1);
    end else if (prev_flag) chk("busy_after_write", int'(busy), 0);
    prev_flag <= flagUC;
  end
  initial begin
    int t;
    repeat (3) @(negedge clock);
    chk("rst_tempRegA", int'(tempRegA), 0);
    chk("rst_flagUC", int'(flagUC), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_flags", int'({carry, zero, error}), 0);
    chk("rst_state", int'(state), 0);
    reset = 1;
    issue(200, 100, 0, 2);
    issue(5, 7, 1, 2);
    issue(9, 9, 1, 2);
    issue(13, 11, 8, 2);
    issue(20, 20, 8, 2);
    issue(8'h5A, 3, 8'hF0, 2);
    issue(8'h81, 0, 6, 2);
    issue(8'h81, 0, 7, 2);
    issue(1, 2, 3, 20);
    issue(13, 11, 8, 2);
    repeat (2) @(negedge clock);
    start = 1;
    repeat (2) @(negedge clock);
    start = 0;
    wait_idle();
    @(negedge clock);
    regA = 77;
    regB = 3;
    opcode = 8;
    start = 1;
    repeat (5) @(negedge clock);
    start = 0;
    reset = 0;
    @(negedge clock);
    chk("midmul_state", int'(state), 0);
    chk("midmul_tempRegA", int'(tempRegA), 0);
    chk("midmul_busy", int'(busy), 0);
    reset = 1;
    repeat (10) @(negedge clock);
    for (int i = 0; i < 40; i++) begin
      int o;
      o = ($urandom % 4 == 0) ? int'($urandom % 256) : int'($urandom % 10);
      issue(int'($urandom % 256), int'($urandom % 256), o, 2 + int'($urandom % 3));
    end
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clock);
      t++;
    end
    chk("queue_drained", q.size(), 0);
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
